debug_unit_ctrl: RTL and testbench

//  Byte-command sequencer between a UART rx/tx pair and the MIPS pipeline.

---
 rtl/debug_unit_ctrl.sv | 218 +++++++++++++++++++++
 tb/tb_debug_unit_ctrl.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/debug_unit_ctrl.sv
// debug_unit_ctrl: byte-command sequencer between the UART and the MIPS pipeline.
// It loads the instruction memory and runs or single-steps the pipeline through a
// clock enable. After halt it drains the pipeline, then streams back a snapshot of
// the latches followed by the enabled-cycle count.
module debug_unit_ctrl #(
   parameter int LEN          = 32,
   parameter int NB_DATA      = 8,
   parameter int N_DUMP_WORDS = 16,
   parameter int DRAIN_CYCLES = 4
) (
   input  logic                            i_clk,
   input  logic                            i_rst,
   input  logic [NB_DATA-1:0]              i_rx_data,
   input  logic                            i_rx_valid,
   output logic [NB_DATA-1:0]              o_tx_data,
   output logic                            o_tx_start,
   input  logic                            i_tx_done,
   output logic                            o_wea_mem_instr,
   output logic [LEN-1:0]                  o_addr_mem_instr,
   output logic [LEN-1:0]                  o_dir_mem_instr,
   output logic                            o_pipe_rst_n,
   output logic                            o_pipe_en,
   input  logic                            i_flag_halt,
   output logic [$clog2(N_DUMP_WORDS)-1:0] o_dump_sel,
   input  logic [LEN-1:0]                  i_dump_word,
   output logic [LEN-1:0]                  o_cant_clock,
   output logic                            o_halted
);

   localparam int SEL_W = $clog2(N_DUMP_WORDS);
   localparam int IDX_W = $clog2(N_DUMP_WORDS + 1);
   localparam int DC_W  = $clog2(DRAIN_CYCLES + 1);
   localparam int CNT_W = 2 * NB_DATA;

   localparam logic [NB_DATA-1:0] CMD_LOAD = NB_DATA'(1);
   localparam logic [NB_DATA-1:0] CMD_RUN  = NB_DATA'(2);
   localparam logic [NB_DATA-1:0] CMD_STEP = NB_DATA'(3);

   localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(N_DUMP_WORDS);
   localparam logic [IDX_W-1:0] LAST_SEL   = IDX_W'(N_DUMP_WORDS - 1);
   localparam logic [DC_W-1:0]  LAST_DRAIN = DC_W'(DRAIN_CYCLES - 1);
   localparam logic [CNT_W-1:0] ONE_CNT    = CNT_W'(1);

   typedef enum logic [3:0] {
      IDLE, LOAD_NH, LOAD_NL, LOAD_BYTE, LOAD_WR,
      RUN, STEP, DRAIN, DUMP_TX, DUMP_WAIT
   } state_t;

   state_t                 state;
   logic [CNT_W-1:0]       n_words;
   logic [CNT_W-1:0]       k;
   logic [LEN-1:0]         word_sr;
   logic [LEN-1:0]         dump_buf;
   logic [1:0]             byte_idx;
   logic [IDX_W-1:0]       dump_idx;
   logic [DC_W-1:0]        drain_cnt;
   logic                   halt_seen;

   logic [LEN-1:0]         word_next;
   logic [LEN-1:0]         dump_src;
   logic [CNT_W-1:0]       n_full;
   logic [CNT_W-1:0]       k_next;

   // Big-endian byte select: byte 0 is the most significant byte of the word.
   function automatic logic [NB_DATA-1:0] byte_of(input logic [LEN-1:0] w, input logic [1:0] idx);
      logic [LEN-1:0] sh;
      sh = w << (NB_DATA * int'(idx));
      return sh[LEN-1 -: NB_DATA];
   endfunction

   // The snapshot word is captured on its first byte; the final word is the cycle count.
   assign word_next = {word_sr[LEN-NB_DATA-1:0], i_rx_data};
   assign dump_src  = (byte_idx != 2'd0) ? dump_buf :
                      (dump_idx == LAST_IDX) ? o_cant_clock : i_dump_word;
   assign n_full    = {n_words[CNT_W-1:NB_DATA], i_rx_data};
   assign k_next    = k + ONE_CNT;

   // Datapath holding registers; they are always written before being read, so they carry no reset.
   always_ff @(posedge i_clk) begin
      if (i_rx_valid && state == LOAD_NH)   n_words[CNT_W-1:NB_DATA] <= i_rx_data;
      if (i_rx_valid && state == LOAD_NL)   n_words[NB_DATA-1:0]     <= i_rx_data;
      if (i_rx_valid && state == LOAD_BYTE) word_sr                  <= word_next;
      if (state == DUMP_TX && byte_idx == 2'd0) dump_buf <= dump_src;
   end

   // Command sequencer; all outputs are registered.
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         state            <= IDLE;
         k                <= '0;
         byte_idx         <= '0;
         dump_idx         <= '0;
         drain_cnt        <= '0;
         halt_seen        <= 1'b0;
         o_tx_data        <= '0;
         o_tx_start       <= 1'b0;
         o_wea_mem_instr  <= 1'b0;
         o_addr_mem_instr <= '0;
         o_dir_mem_instr  <= '0;
         o_pipe_rst_n     <= 1'b0;
         o_pipe_en        <= 1'b0;
         o_dump_sel       <= '0;
         o_cant_clock     <= '0;
         o_halted         <= 1'b0;
      end else begin
         o_wea_mem_instr <= 1'b0;
         o_tx_start      <= 1'b0;
         case (state)
            IDLE: if (i_rx_valid) begin
               case (i_rx_data)
                  CMD_LOAD: begin
                     o_pipe_rst_n <= 1'b0;
                     k            <= '0;
                     o_cant_clock <= '0;
                     o_halted     <= 1'b0;
                     halt_seen    <= 1'b0;
                     drain_cnt    <= '0;
                     state        <= LOAD_NH;
                  end
                  CMD_RUN: begin
                     if (o_halted) begin
                        state <= DUMP_TX;
                     end else begin
                        // A halt already seen while stepping continues the drain.
                        o_pipe_en <= 1'b1;
                        state     <= halt_seen ? DRAIN : RUN;
                     end
                  end
                  CMD_STEP: begin
                     if (o_halted) begin
                        state <= DUMP_TX;
                     end else begin
                        o_pipe_en <= 1'b1;
                        state     <= STEP;
                     end
                  end
                  default: ;
               endcase
            end
            LOAD_NH: if (i_rx_valid) state <= LOAD_NL;
            LOAD_NL: if (i_rx_valid) begin
               if (n_full == '0) begin
                  o_pipe_rst_n <= 1'b1;
                  state        <= IDLE;
               end else begin
                  byte_idx <= '0;
                  state    <= LOAD_BYTE;
               end
            end
            LOAD_BYTE: if (i_rx_valid) begin
               byte_idx <= byte_idx + 2'd1;
               if (byte_idx == 2'd3) begin
                  o_wea_mem_instr  <= 1'b1;
                  o_addr_mem_instr <= LEN'(k);
                  o_dir_mem_instr  <= word_next;
                  state            <= LOAD_WR;
               end
            end
            LOAD_WR: begin
               k <= k_next;
               if (k_next == n_words) begin
                  o_pipe_rst_n <= 1'b1;
                  state        <= IDLE;
               end else begin
                  state <= LOAD_BYTE;
               end
            end
            RUN: begin
               o_cant_clock <= o_cant_clock + LEN'(1);
               if (i_flag_halt) state <= DRAIN;
            end
            DRAIN: begin
               o_cant_clock <= o_cant_clock + LEN'(1);
               if (drain_cnt == LAST_DRAIN) begin
                  o_pipe_en <= 1'b0;
                  o_halted  <= 1'b1;
                  state     <= DUMP_TX;
               end else begin
                  drain_cnt <= drain_cnt + DC_W'(1);
               end
            end
            STEP: begin
               o_cant_clock <= o_cant_clock + LEN'(1);
               o_pipe_en    <= 1'b0;
               state        <= DUMP_TX;
               if (halt_seen) begin
                  if (drain_cnt == LAST_DRAIN) o_halted <= 1'b1;
                  else                         drain_cnt <= drain_cnt + DC_W'(1);
               end else if (i_flag_halt) begin
                  halt_seen <= 1'b1;
               end
            end
            DUMP_TX: begin
               o_tx_data  <= byte_of(dump_src, byte_idx);
               o_tx_start <= 1'b1;
               state      <= DUMP_WAIT;
            end
            DUMP_WAIT: if (i_tx_done) begin
               byte_idx <= byte_idx + 2'd1;
               state    <= DUMP_TX;
               if (byte_idx == 2'd3) begin
                  if (dump_idx == LAST_IDX) begin
                     // Leave the dump counters cleared so the next dump starts at word 0.
                     dump_idx   <= '0;
                     o_dump_sel <= '0;
                     state      <= IDLE;
                  end else begin
                     dump_idx <= dump_idx + IDX_W'(1);
                     if (dump_idx < LAST_SEL) o_dump_sel <= SEL_W'(dump_idx + IDX_W'(1));
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_debug_unit_ctrl.sv
// Directed bench for debug_unit_ctrl: load, run/drain, step, halted re-run,
// tx handshake, stepping drain and asynchronous reset.
module tb_debug_unit_ctrl;

   localparam int LEN = 32;
   localparam int NB  = 8;
   localparam int NW  = 16;
   localparam int DC  = 4;
   localparam int DUMP_BYTES = 4 * (NW + 1);

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic [NB-1:0] rx_data = '0;
   logic          rx_valid = 1'b0;
   logic [NB-1:0] tx_data;
   logic          tx_start;
   logic          done_resp = 1'b0;
   logic          done_stray = 1'b0;
   logic          tx_done;
   logic          wea;
   logic [LEN-1:0] addr, dir;
   logic          pipe_rst_n, pipe_en;
   logic          flag_halt = 1'b0;
   logic [3:0]    dump_sel;
   logic [LEN-1:0] dump_word;
   logic [LEN-1:0] cant;
   logic          halted;

   assign tx_done   = done_resp | done_stray;
   assign dump_word = {4'hA, dump_sel, 4'hB, dump_sel, 4'hC, dump_sel, 4'hD, dump_sel};

   debug_unit_ctrl #(.LEN(LEN), .NB_DATA(NB), .N_DUMP_WORDS(NW), .DRAIN_CYCLES(DC)) dut (
      .i_clk(clk), .i_rst(rst), .i_rx_data(rx_data), .i_rx_valid(rx_valid),
      .o_tx_data(tx_data), .o_tx_start(tx_start), .i_tx_done(tx_done),
      .o_wea_mem_instr(wea), .o_addr_mem_instr(addr), .o_dir_mem_instr(dir),
      .o_pipe_rst_n(pipe_rst_n), .o_pipe_en(pipe_en), .i_flag_halt(flag_halt),
      .o_dump_sel(dump_sel), .i_dump_word(dump_word), .o_cant_clock(cant), .o_halted(halted)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Monitors: write strobes, enabled cycles and enable pulses.
   int          wea_n = 0;
   logic [31:0] wea_addr[$];
   logic [31:0] wea_data[$];
   int          en_n = 0;
   int          en_rise = 0;
   logic        en_prev = 1'b0;
   always @(negedge clk) begin
      if (wea) begin
         wea_n++;
         wea_addr.push_back(addr);
         wea_data.push_back(dir);
      end
      if (pipe_en) en_n++;
      if (pipe_en && !en_prev) en_rise++;
      en_prev = pipe_en;
   end

   // Transmitter model: logs every started byte and answers with i_tx_done.
   int         tx_n = 0;
   logic [7:0] txlog[$];
   int         done_dly = 3;
   bit         stray_tx = 1'b0;
   always begin
      @(negedge clk);
      while (tx_start) begin
         txlog.push_back(tx_data);
         tx_n++;
         repeat (done_dly) @(negedge clk);
         done_resp = 1'b1;
         @(negedge clk);
         if (stray_tx) @(negedge clk);
         done_resp = 1'b0;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic send_byte(input logic [7:0] b);
      @(negedge clk);
      rx_data  = b;
      rx_valid = 1'b1;
      @(negedge clk);
      rx_valid = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   task automatic load1(input logic [31:0] w);
      send_byte(8'h01); send_byte(8'h00); send_byte(8'h01);
      for (int i = 0; i < 4; i++) send_byte(w[31-8*i -: 8]);
   endtask

   task automatic wait_tx(input int target);
      for (int i = 0; i < 3000 && tx_n < target; i++) @(negedge clk);
      chk("tx_byte_count", 32'(tx_n), 32'(target));
      repeat (4) @(negedge clk);
   endtask

   task automatic check_dump(input int start, input logic [31:0] cnt);
      logic [7:0] e;
      for (int w = 0; w <= NW; w++) begin
         for (int j = 0; j < 4; j++) begin
            if (w < NW) e = {4'(10 + j), 4'(w)};
            else        e = 8'(cnt >> (24 - 8 * j));
            chk("dump_byte", 32'(txlog[start + 4 * w + j]), 32'(e));
         end
      end
   endtask

   int base_en, base_rise, base_tx, base_wea;

   initial begin
      // Reset values
      repeat (3) @(negedge clk);
      chk("rst_pipe_rst_n", 32'(pipe_rst_n), 0);
      chk("rst_pipe_en", 32'(pipe_en), 0);
      chk("rst_wea", 32'(wea), 0);
      chk("rst_tx_start", 32'(tx_start), 0);
      chk("rst_halted", 32'(halted), 0);
      chk("rst_cant", cant, 0);
      chk("rst_addr", addr, 0);
      chk("rst_dir", dir, 0);
      chk("rst_dump_sel", 32'(dump_sel), 0);
      chk("rst_tx_data", 32'(tx_data), 0);
      rst = 1'b1;
      @(negedge clk);

      // T1: two-word load
      send_byte(8'h01);
      chk("t1_pipe_held", 32'(pipe_rst_n), 0);
      send_byte(8'h00); send_byte(8'h02);
      send_byte(8'hDE); send_byte(8'hAD); send_byte(8'hBE); send_byte(8'hEF);
      send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'h2A);
      chk("t1_wea_count", 32'(wea_n), 2);
      chk("t1_addr0", wea_addr[0], 32'h0);
      chk("t1_data0", wea_data[0], 32'hDEADBEEF);
      chk("t1_addr1", wea_addr[1], 32'h1);
      chk("t1_data1", wea_data[1], 32'h0000002A);
      chk("t1_pipe_released", 32'(pipe_rst_n), 1);
      chk("t1_no_enable", 32'(en_n), 0);

      // T2: run, halt after 10 enabled cycles, drain 4
      load1(32'h00000001);
      chk("t2_wea_count", 32'(wea_n), 3);
      base_en = en_n;
      base_tx = tx_n;
      @(negedge clk);
      rx_data = 8'h02; rx_valid = 1'b1;
      @(negedge clk);
      rx_valid = 1'b0;
      for (int i = 0; i < 200 && (en_n - base_en) < 10; i++) begin
         @(posedge clk);
         #1;
      end
      flag_halt = 1'b1;
      for (int i = 0; i < 100 && !halted; i++) @(negedge clk);
      flag_halt = 1'b0;
      chk("t2_enabled_cycles", 32'(en_n - base_en), 15);
      chk("t2_cant", cant, 15);
      chk("t2_halted", 32'(halted), 1);
      wait_tx(base_tx + DUMP_BYTES);
      check_dump(base_tx, 32'd15);
      chk("t2_pipe_en_off", 32'(pipe_en), 0);

      // T4: RUN while halted just dumps
      base_en = en_n;
      base_tx = tx_n;
      send_byte(8'h02);
      wait_tx(base_tx + DUMP_BYTES);
      chk("t4_no_enable", 32'(en_n - base_en), 0);
      chk("t4_cant", cant, 15);
      chk("t4_halted", 32'(halted), 1);
      check_dump(base_tx, 32'd15);

      // T3: three single steps
      load1(32'h12345678);
      chk("t3_halted_cleared", 32'(halted), 0);
      chk("t3_cant_cleared", cant, 0);
      base_en   = en_n;
      base_rise = en_rise;
      base_tx   = tx_n;
      for (int s = 0; s < 3; s++) begin
         send_byte(8'h03);
         wait_tx(base_tx + DUMP_BYTES * (s + 1));
         check_dump(base_tx + DUMP_BYTES * s, 32'(s + 1));
      end
      chk("t3_enabled_cycles", 32'(en_n - base_en), 3);
      chk("t3_enable_pulses", 32'(en_rise - base_rise), 3);
      chk("t3_cant", cant, 3);

      // T5: slow tx_done, stray tx_done in DUMP_TX, rx bytes during dump
      base_en = en_n;
      base_tx = tx_n;
      done_dly = 50;
      stray_tx = 1'b1;
      send_byte(8'h03);
      for (int i = 0; i < 200 && tx_n < base_tx + 1; i++) @(negedge clk);
      done_dly = 3;
      repeat (40) @(negedge clk);
      chk("t5_single_start", 32'(tx_n), 32'(base_tx + 1));
      send_byte(8'h01);
      send_byte(8'h02);
      wait_tx(base_tx + DUMP_BYTES);
      stray_tx = 1'b0;
      check_dump(base_tx, 32'd4);
      chk("t5_no_load", 32'(pipe_rst_n), 1);
      chk("t5_one_enable", 32'(en_n - base_en), 1);
      base_tx = tx_n;
      @(negedge clk);
      done_stray = 1'b1;
      repeat (3) @(negedge clk);
      done_stray = 1'b0;
      repeat (3) @(negedge clk);
      chk("t5_idle_done_ignored", 32'(tx_n), 32'(base_tx));
      chk("t5_idle_no_enable", 32'(pipe_en), 0);

      // Halt seen while stepping; four more steps drain the pipeline
      base_tx = tx_n;
      flag_halt = 1'b1;
      send_byte(8'h03);
      flag_halt = 1'b0;
      wait_tx(base_tx + DUMP_BYTES);
      chk("step_halt_cant", cant, 5);
      chk("step_halt_not_yet", 32'(halted), 0);
      for (int s = 0; s < 3; s++) begin
         send_byte(8'h03);
         wait_tx(base_tx + DUMP_BYTES * (s + 2));
      end
      chk("step_drain3_halted", 32'(halted), 0);
      chk("step_drain3_cant", cant, 8);
      send_byte(8'h03);
      wait_tx(base_tx + DUMP_BYTES * 5);
      chk("step_drain4_halted", 32'(halted), 1);
      chk("step_drain4_cant", cant, 9);
      check_dump(base_tx + DUMP_BYTES * 4, 32'd9);
      base_en = en_n;
      send_byte(8'h03);
      wait_tx(base_tx + DUMP_BYTES * 6);
      chk("step_after_halt_no_enable", 32'(en_n - base_en), 0);
      chk("step_after_halt_cant", cant, 9);

      // T6: asynchronous reset in the middle of a load
      base_wea = wea_n;
      send_byte(8'h01); send_byte(8'h00); send_byte(8'h02);
      send_byte(8'hAA); send_byte(8'hBB);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("t6_pipe_rst_n", 32'(pipe_rst_n), 0);
      chk("t6_cant", cant, 0);
      chk("t6_halted", 32'(halted), 0);
      chk("t6_pipe_en", 32'(pipe_en), 0);
      chk("t6_tx_data", 32'(tx_data), 0);
      chk("t6_addr", addr, 0);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      send_byte(8'h01); send_byte(8'h00); send_byte(8'h00);
      repeat (2) @(negedge clk);
      chk("t6_empty_load_release", 32'(pipe_rst_n), 1);
      chk("t6_no_wea", 32'(wea_n), 32'(base_wea));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
